// File: rtl/fir_pkg.sv
// Shared definitions for the MSO FIR filter blocks: loader FSM state
// encodings, default datapath widths and an index-width helper.
package fir_pkg;

  // Default widths shared with the FIR datapath.
  localparam int DEF_COEFF_WIDTH = 8;
  localparam int DEF_NUM_TAPS    = 4;

  // Coefficient loader FSM encodings.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_LOAD    = 2'd1;
  localparam logic [1:0] ST_DRAIN   = 2'd2;
  localparam logic [1:0] ST_PENDING = 2'd3;

  // Width of a tap index; a single-tap filter still needs a 1-bit counter.
  function automatic int idx_width(input int taps);
    return (taps > 1) ? $clog2(taps) : 1;
  endfunction

endpackage

// File: rtl/fir_coeff_loader.sv
// Coefficient writer for the MSO FIR filter. Collects one coefficient frame
// from a valid/ready stream into a shadow bank and commits the full bank to
// packed_coeffs on a sample-boundary strobe, so taps never change piecemeal.
module fir_coeff_loader
  import fir_pkg::*;
#(
  parameter int COEFF_WIDTH = DEF_COEFF_WIDTH,
  parameter int NUM_TAPS    = DEF_NUM_TAPS,
  parameter logic [COEFF_WIDTH*NUM_TAPS-1:0] RESET_COEFFS = {(COEFF_WIDTH*NUM_TAPS){1'b0}}
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            cfg_valid,
  output logic                            cfg_ready,
  input  logic [COEFF_WIDTH-1:0]          cfg_data,
  input  logic                            cfg_last,
  input  logic                            commit_en,
  output logic [COEFF_WIDTH*NUM_TAPS-1:0] packed_coeffs,
  output logic                            coeff_update,
  output logic                            load_error,
  output logic                            busy
);

  localparam int IDX_W = idx_width(NUM_TAPS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TAPS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  logic [1:0]                      state_r;
  logic [IDX_W-1:0]                idx_r;
  logic [COEFF_WIDTH-1:0]          shadow_r [NUM_TAPS];
  logic [COEFF_WIDTH*NUM_TAPS-1:0] packed_coeffs_r;
  logic [COEFF_WIDTH*NUM_TAPS-1:0] shadow_packed_s;
  logic                            coeff_update_r;
  logic                            load_error_r;
  logic                            beat_s;

  // Ready depends on registered state only; PENDING is the only stall.
  assign cfg_ready     = (state_r != ST_PENDING);
  assign busy          = (state_r != ST_IDLE);
  assign beat_s        = cfg_valid & cfg_ready;
  assign packed_coeffs = packed_coeffs_r;
  assign coeff_update  = coeff_update_r;
  assign load_error    = load_error_r;

  // Flatten the shadow bank into the packed bus layout (tap i at slice i).
  always_comb begin
    shadow_packed_s = {(COEFF_WIDTH*NUM_TAPS){1'b0}};
    for (int i = 0; i < NUM_TAPS; i++) begin
      shadow_packed_s[COEFF_WIDTH*i +: COEFF_WIDTH] = shadow_r[i];
    end
  end

  // Frame FSM, index counter, shadow bank and active tap register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r         <= ST_IDLE;
      idx_r           <= {IDX_W{1'b0}};
      packed_coeffs_r <= RESET_COEFFS;
      coeff_update_r  <= 1'b0;
      load_error_r    <= 1'b0;
      for (int i = 0; i < NUM_TAPS; i++) begin
        shadow_r[i] <= {COEFF_WIDTH{1'b0}};
      end
    end else begin
      coeff_update_r <= 1'b0;
      load_error_r   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (beat_s) begin
            shadow_r[0] <= cfg_data;
            if (NUM_TAPS == 1) begin
              // A single-tap frame is complete on its first beat; a missing
              // last flag means more beats follow, i.e. a long frame.
              if (cfg_last) begin
                state_r <= ST_PENDING;
              end else begin
                load_error_r <= 1'b1;
                state_r      <= ST_DRAIN;
              end
            end else if (cfg_last) begin
              load_error_r <= 1'b1;
            end else begin
              idx_r   <= IDX_ONE;
              state_r <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          if (beat_s) begin
            shadow_r[idx_r] <= cfg_data;
            if (idx_r == LAST_IDX) begin
              if (cfg_last) begin
                state_r <= ST_PENDING;
              end else begin
                load_error_r <= 1'b1;
                state_r      <= ST_DRAIN;
              end
            end else if (cfg_last) begin
              load_error_r <= 1'b1;
              state_r      <= ST_IDLE;
            end else begin
              idx_r <= idx_r + IDX_ONE;
            end
          end
        end
        ST_DRAIN: begin
          // Surplus beats of a long frame are swallowed until its last beat.
          if (beat_s && cfg_last) begin
            state_r <= ST_IDLE;
          end
        end
        ST_PENDING: begin
          if (commit_en) begin
            packed_coeffs_r <= shadow_packed_s;
            coeff_update_r  <= 1'b1;
            state_r         <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
